// File: rtl/bnd_chk.sv
// bnd_chk: bounded-pointer decode and range check, 3-stage valid/ready pipeline (field extract, bound assembly, compare).
// Define BND_CHK_STICKY_FAULT_EN to add fault_clr/fault_sticky; ptr_low's two LSBs share bits [43:42] with the address.
module bnd_chk #(
    parameter int RNG_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [64:0] ptr,
    input  logic [43:0] off,
    input  logic [3:0]  size,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [43:0] addr,
    output logic [43:0] lo,
    output logic [43:0] hi,
    output logic [1:0]  fault
`ifdef BND_CHK_STICKY_FAULT_EN
    ,
    input  logic        fault_clr,
    output logic [1:0]  fault_sticky
`endif
);
    localparam int AW        = 44;
    localparam int TAG_BIT   = 64;
    localparam int ONLOW_BIT = 63;
    localparam int EXP_LSB   = 58;
    localparam int HI_LSB    = EXP_LSB - RNG_W;
    localparam int LOW_LSB   = HI_LSB - RNG_W;

    function automatic logic [1:0] classify(input logic tg, input logic bad,
                                            input logic [AW-1:0] a, input logic [AW-1:0] l,
                                            input logic [AW-1:0] h, input logic [3:0] sz);
        logic [AW:0] end_a;
        end_a = {1'b0, a} + {{(AW-3){1'b0}}, sz};
        if (bad) return 2'd3;
        if (!tg) return 2'd0;
        if (a < l) return 2'd1;
        if (end_a > {1'b0, h}) return 2'd2;
        return 2'd0;
    endfunction

    logic               adv_p1, adv_p2, adv_p3;
    logic               vld_p1_q, vld_p2_q, vld_p3_q;

    logic signed [AW-1:0] off_s, addr_s0;
    logic [5:0]         p_s0;
    logic [RNG_W-1:0]   w_s0, low_s0, hi_s0;
    logic [AW-1:0]      top_s0;
    logic [3:0]         size_s0;

    logic [AW-1:0]      addr_p1_q, top_p1_q;
    logic [RNG_W-1:0]   low_p1_q, hi_p1_q;
    logic [5:0]         p_p1_q;
    logic               borrow_p1_q, carry_p1_q, tag_p1_q, bad_p1_q;
    logic [3:0]         size_p1_q;

    logic [AW-1:0]      ltop, htop, lo_d, hi_d;
    logic [AW-1:0]      addr_p2_q, lo_p2_q, hi_p2_q;
    logic               tag_p2_q, bad_p2_q;
    logic [3:0]         size_p2_q;

    logic [1:0]         fault_d;
    logic [AW-1:0]      addr_q, lo_q, hi_q;
    logic [1:0]         fault_q;

    // Handshake: a stage loads when empty or when the stage after it advances.
    assign adv_p3  = ~vld_p3_q | out_rdy;
    assign adv_p2  = ~vld_p2_q | adv_p3;
    assign adv_p1  = ~vld_p1_q | adv_p2;
    assign in_rdy  = adv_p1;
    assign out_vld = vld_p3_q;
    assign addr    = addr_q;
    assign lo      = lo_q;
    assign hi      = hi_q;
    assign fault   = fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
        end else begin
            if (adv_p1) vld_p1_q <= in_vld;
            if (adv_p2) vld_p2_q <= vld_p1_q;
            if (adv_p3) vld_p3_q <= vld_p2_q;
        end
    end

    // Stage 1: field extract, effective address, window compare.
    assign off_s   = signed'(off);
    assign addr_s0 = signed'(ptr[AW-1:0]) + off_s;
    assign p_s0    = {1'b0, ptr[EXP_LSB +: 5]} + 6'd4;
    assign w_s0    = RNG_W'(ptr[AW-1:0] >> p_s0);
    assign top_s0  = ptr[AW-1:0] >> (p_s0 + 6'(RNG_W));
    assign low_s0  = ptr[LOW_LSB +: RNG_W];
    assign hi_s0   = ptr[HI_LSB +: RNG_W];
    assign size_s0 = (size == 4'd0) ? 4'd1 : size;

    always_ff @(posedge clk) begin
        if (adv_p1 && in_vld) begin
            addr_p1_q   <= addr_s0;
            top_p1_q    <= top_s0;
            low_p1_q    <= low_s0;
            hi_p1_q     <= hi_s0;
            p_p1_q      <= p_s0;
            borrow_p1_q <= (w_s0 < low_s0);
            carry_p1_q  <= (hi_s0 < low_s0);
            tag_p1_q    <= ptr[TAG_BIT];
            bad_p1_q    <= ptr[TAG_BIT] & ~ptr[ONLOW_BIT];
            size_p1_q   <= size_s0;
        end
    end

    // Stage 2: top-field correction and bound assembly; shifting out the high bits wraps Ltop/Htop.
    always_comb begin
        ltop = top_p1_q - {{(AW-1){1'b0}}, borrow_p1_q};
        htop = ltop + {{(AW-1){1'b0}}, carry_p1_q};
        lo_d = (ltop << (p_p1_q + 6'(RNG_W))) | (AW'(low_p1_q) << p_p1_q);
        hi_d = (htop << (p_p1_q + 6'(RNG_W))) | (AW'(hi_p1_q) << p_p1_q);
        if (!tag_p1_q) begin
            lo_d = '0;
            hi_d = '1;
        end else if (bad_p1_q) begin
            lo_d = '0;
            hi_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (adv_p2 && vld_p1_q) begin
            addr_p2_q <= addr_p1_q;
            lo_p2_q   <= lo_d;
            hi_p2_q   <= hi_d;
            tag_p2_q  <= tag_p1_q;
            bad_p2_q  <= bad_p1_q;
            size_p2_q <= size_p1_q;
        end
    end

    // Stage 3: range compares into the output register.
    assign fault_d = classify(tag_p2_q, bad_p2_q, addr_p2_q, lo_p2_q, hi_p2_q, size_p2_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            fault_q <= '0;
        end else if (adv_p3 && vld_p2_q) begin
            addr_q  <= addr_p2_q;
            lo_q    <= lo_p2_q;
            hi_q    <= hi_p2_q;
            fault_q <= fault_d;
        end
    end

`ifdef BND_CHK_STICKY_FAULT_EN
    logic [1:0] sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (fault_clr) sticky_d = 2'd0;
        // A fault delivered in the same cycle as a clear takes precedence.
        if (out_vld && out_rdy && (fault_q != 2'd0) && ((sticky_q == 2'd0) || fault_clr))
            sticky_d = fault_q;
    end

    always_ff @(posedge clk) begin
        if (rst) sticky_q <= 2'd0;
        else     sticky_q <= sticky_d;
    end

    assign fault_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_bnd_chk.sv
// Scoreboard bench for bnd_chk: directed test-plan cases, backpressure, random traffic, reset mid-flight.
module tb_bnd_chk;
    logic        clk = 1'b0;
    logic        rst, in_vld, in_rdy, out_vld, out_rdy;
    logic [64:0] ptr;
    logic [43:0] off;
    logic [3:0]  size;
    logic [43:0] addr, lo, hi;
    logic [1:0]  fault;
`ifdef BND_CHK_STICKY_FAULT_EN
    logic        fault_clr;
    logic [1:0]  fault_sticky;
`endif

    typedef struct {
        logic [43:0] addr;
        logic [43:0] lo;
        logic [43:0] hi;
        logic [1:0]  fault;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    exp_t dir_exp;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   use_model = 1'b1;
    bit   lat_chk = 1'b0;
    bit   rand_on = 1'b0;
    logic [1:0] sm = 2'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    bnd_chk dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
        .ptr(ptr), .off(off), .size(size),
        .out_vld(out_vld), .out_rdy(out_rdy),
        .addr(addr), .lo(lo), .hi(hi), .fault(fault)
`ifdef BND_CHK_STICKY_FAULT_EN
        , .fault_clr(fault_clr), .fault_sticky(fault_sticky)
`endif
    );

    function automatic logic [64:0] mkptr(input bit tg, input bit onl, input logic [4:0] e,
                                          input logic [7:0] lowf, input logic [7:0] hif,
                                          input logic [43:0] a);
        logic [64:0] w;
        w = {21'd0, a};
        w[64] = tg;
        w[63] = onl;
        w[62:58] = e;
        w[57:50] = hif;
        w[49:42] = lowf;
        return w;
    endfunction

    function automatic exp_t mkexp(input logic [43:0] a, input logic [43:0] l,
                                   input logic [43:0] h, input logic [1:0] f);
        exp_t r;
        r.addr = a; r.lo = l; r.hi = h; r.fault = f; r.acc = 0; r.lat = 1'b0;
        return r;
    endfunction

    // Reference: bounds rebuilt as Ltop*2^(p+8) + low*2^p with modular top arithmetic.
    function automatic exp_t model(input logic [64:0] p, input logic [43:0] o, input logic [3:0] s);
        exp_t r;
        longint unsigned m44, a, ad, w, t, tmod, lt, ht, lov, hiv, sz, lowf, hif;
        int pp;
        m44 = (64'd1 << 44) - 64'd1;
        a = 64'(p[43:0]);
        ad = (a + 64'(o)) & m44;
        r.addr = ad[43:0];
        r.acc = 0;
        r.lat = 1'b0;
        if (!p[64]) begin
            r.lo = '0; r.hi = '1; r.fault = 2'd0;
        end else if (!p[63]) begin
            r.lo = '0; r.hi = '0; r.fault = 2'd3;
        end else begin
            pp = int'(p[62:58]) + 4;
            lowf = 64'(p[49:42]);
            hif = 64'(p[57:50]);
            w = (a >> pp) % 64'd256;
            t = a >> (pp + 8);
            tmod = 64'd1 << (44 - pp - 8);
            lt = (t + tmod - ((w < lowf) ? 64'd1 : 64'd0)) % tmod;
            ht = (lt + ((hif < lowf) ? 64'd1 : 64'd0)) % tmod;
            lov = lt * (64'd1 << (pp + 8)) + lowf * (64'd1 << pp);
            hiv = ht * (64'd1 << (pp + 8)) + hif * (64'd1 << pp);
            sz = (s == 4'd0) ? 64'd1 : 64'(s);
            r.lo = lov[43:0];
            r.hi = hiv[43:0];
            if (ad < lov) r.fault = 2'd1;
            else if (ad + sz > hiv) r.fault = 2'd2;
            else r.fault = 2'd0;
        end
        return r;
    endfunction

    // Monitor: pops and compares whenever the DUT presents a result; records accepted requests.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            sm = 2'd0;
        end else begin
`ifdef BND_CHK_STICKY_FAULT_EN
            checks++;
            if (fault_sticky !== sm) begin
                failures++;
                $display("FAIL sticky got=%0d exp=%0d", fault_sticky, sm);
            end
            if (fault_clr) sm = 2'd0;
`endif
            if (out_vld) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_out addr=%h fault=%0d exp no output", addr, fault);
                end else begin
                    e = sb[0];
                    checks++;
                    if (addr !== e.addr || lo !== e.lo || hi !== e.hi || fault !== e.fault) begin
                        failures++;
                        $display("FAIL result got addr=%h lo=%h hi=%h fault=%0d exp addr=%h lo=%h hi=%h fault=%0d",
                                 addr, lo, hi, fault, e.addr, e.lo, e.hi, e.fault);
                    end
                    if (out_rdy) begin
                        if (e.lat) begin
                            checks++;
                            if (cyc - e.acc != 3) begin
                                failures++;
                                $display("FAIL latency got=%0d exp=3", cyc - e.acc);
                            end
                        end
`ifdef BND_CHK_STICKY_FAULT_EN
                        if (e.fault != 2'd0 && (fault_sticky == 2'd0 || fault_clr)) sm = e.fault;
`endif
                        void'(sb.pop_front());
                    end
                end
            end
            if (in_vld && in_rdy) begin
                e = use_model ? model(ptr, off, size) : dir_exp;
                e.acc = cyc;
                e.lat = lat_chk;
                sb.push_back(e);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_on) begin
            #1;
            out_rdy = ($urandom % 4) != 0;
`ifdef BND_CHK_STICKY_FAULT_EN
            fault_clr = ($urandom % 8) == 0;
`endif
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [64:0] p, input logic [43:0] o, input logic [3:0] s);
        int n;
        ptr = p; off = o; size = s; in_vld = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_rdy) break;
            n++;
            if (n > 500) begin
                checks++; failures++;
                $display("FAIL send_timeout in_rdy=0 exp 1");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_dir(input logic [64:0] p, input logic [43:0] o, input logic [3:0] s, input exp_t e);
        use_model = 1'b0;
        lat_chk = 1'b1;
        dir_exp = e;
        send(p, o, s);
    endtask

    task automatic drain();
        int n;
        in_vld = 1'b0;
        n = 0;
        while ((sb.size() != 0 || out_vld) && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [64:0] p1, p2, p3, pr;
        logic [64:0] bp_ptr[4];
        logic [43:0] bp_off[4];
        logic [43:0] ra;
        logic [4:0]  re;
        int idx, sv;
        bit acc;

        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1; ptr = '0; off = '0; size = '0;
`ifdef BND_CHK_STICKY_FAULT_EN
        fault_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);

        p1 = mkptr(1'b1, 1'b1, 5'd0, 8'h10, 8'h20, 44'h150);
        p2 = mkptr(1'b1, 1'b1, 5'd0, 8'hF0, 8'h10, 44'h1F80);
        p3 = mkptr(1'b1, 1'b1, 5'd0, 8'hF0, 8'h10, 44'h2050);
        send_dir(p1, 44'h0, 4'd8, mkexp(44'h150, 44'h100, 44'h200, 2'd0));
        send_dir(p1, 44'hFFF_FFFF_FFA0, 4'd8, mkexp(44'h0F0, 44'h100, 44'h200, 2'd1));
        send_dir(p1, 44'h0AC, 4'd8, mkexp(44'h1FC, 44'h100, 44'h200, 2'd2));
        send_dir(p1, 44'h0A8, 4'd8, mkexp(44'h1F8, 44'h100, 44'h200, 2'd0));
        send_dir(p1, 44'hFFF_FFFF_FFB0, 4'd1, mkexp(44'h100, 44'h100, 44'h200, 2'd0));
        send_dir(p1, 44'h0AF, 4'd0, mkexp(44'h1FF, 44'h100, 44'h200, 2'd0));
        send_dir(p2, 44'h0, 4'd8, mkexp(44'h1F80, 44'h1F00, 44'h2100, 2'd0));
        send_dir(p3, 44'h0, 4'd8, mkexp(44'h2050, 44'h1F00, 44'h2100, 2'd0));
        send_dir(mkptr(1'b1, 1'b0, 5'd0, 8'h10, 8'h20, 44'h150), 44'h0, 4'd4,
                 mkexp(44'h150, 44'h0, 44'h0, 2'd3));
        send_dir(mkptr(1'b0, 1'b1, 5'd0, 8'h10, 8'h20, 44'h150), 44'h10, 4'd4,
                 mkexp(44'h160, 44'h0, 44'hFFF_FFFF_FFFF, 2'd0));
        drain();

        // Backpressure: four back-to-back requests against a stalled output.
        use_model = 1'b1; lat_chk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bp_ptr[i] = mkptr(1'b1, 1'b1, 5'd0, 8'h10, 8'h20, 44'h150);
            bp_off[i] = 44'(i * 32 - 48);
        end
        out_rdy = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            ptr = bp_ptr[idx]; off = bp_off[idx]; size = 4'd4; in_vld = 1'b1;
            @(negedge clk);
            acc = in_rdy;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'd3);
        @(negedge clk);
        chk("bp_in_rdy_low", 64'(in_rdy), 64'd0);
        @(posedge clk); #1;
        out_rdy = 1'b1;
        send(bp_ptr[3], bp_off[3], 4'd4);
        drain();

        // Random traffic with random backpressure.
        rand_on = 1'b1;
        for (int i = 0; i < 300; i++) begin
            re = ($urandom % 2) ? 5'($urandom_range(0, 6)) : 5'($urandom_range(0, 31));
            ra = ($urandom % 2) ? 44'($urandom_range(0, 'hFFFFF)) : {12'($urandom), 32'($urandom)};
            pr = mkptr(($urandom % 10) != 0, ($urandom % 10) != 0, re, 8'($urandom), 8'($urandom), ra);
            if ($urandom % 2) begin
                sv = int'($urandom_range(0, 1023)) - 512;
                off = 44'(sv);
            end else begin
                off = {12'($urandom), 32'($urandom)};
            end
            send(pr, off, 4'($urandom_range(0, 8)));
            if ($urandom % 4 == 0) begin
                in_vld = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_vld = 1'b0;
        rand_on = 1'b0;
        @(posedge clk); #2;
        out_rdy = 1'b1;
`ifdef BND_CHK_STICKY_FAULT_EN
        fault_clr = 1'b0;
`endif
        drain();

        // Reset with three requests in flight.
        send(p1, 44'h0, 4'd8);
        send(p1, 44'h10, 4'd8);
        send(p1, 44'hFFF_FFFF_FFA0, 4'd8);
        rst = 1'b1; in_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_out_vld", 64'(out_vld), 64'd0);
        chk("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
        chk("mid_rst_fault", 64'(fault), 64'd0);
`ifdef BND_CHK_STICKY_FAULT_EN
        chk("mid_rst_sticky", 64'(fault_sticky), 64'd0);
`endif
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_queue", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, exp finish");
        $fatal(1, "watchdog");
    end

endmodule
